// File: rtl/cim_dot_scheduler.sv
// ---------------------------------------------------------------------------
// cim_dot_scheduler
//
// Shares a single BF16 dot-product compute-in-memory engine among NREQ
// requesters. A round-robin arbiter picks one pending requester and latches
// its A/B operand vectors. The scheduler then pulses the engine start, times
// the fixed engine latency with a down-counter (the engine has no done flag),
// captures the 16-bit result and returns it over a valid/ready handshake.
// Only one job is ever in flight.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_enable        gates new grants; an in-flight job always completes
//   req_valid[NREQ]   per-requester request
//   req_ready[NREQ]   one-hot accept strobe (combinational, IDLE only)
//   req_a, req_b      packed operand vectors, requester i at [i*16*SIZE +: 16*SIZE]
//   eng_start         one-cycle start pulse to the engine
//   eng_a, eng_b      latched operands, stable from ISSUE to the end of WAIT
//   eng_out           engine BF16 result, sampled in the last WAIT cycle only
//   rsp_valid[NREQ]   one-hot response valid to the granted requester
//   rsp_ready[NREQ]   per-requester response ready (only the grant's bit counts)
//   rsp_data          captured BF16 result
//   busy              high whenever the FSM is not in IDLE
//   job_count         completed response handshakes, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module cim_dot_scheduler #(
    parameter int NREQ       = 4,
    parameter int SIZE       = 2,
    parameter int ENGINE_LAT = 10,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_enable,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*16*SIZE-1:0] req_a,
    input  logic [NREQ*16*SIZE-1:0] req_b,
    output logic                   eng_start,
    output logic [16*SIZE-1:0]     eng_a,
    output logic [16*SIZE-1:0]     eng_b,
    input  logic [15:0]            eng_out,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [15:0]            rsp_data,
    output logic                   busy,
    output logic [CNT_W-1:0]       job_count
);

    localparam int VW    = 16 * SIZE;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LAT_W = $clog2(ENGINE_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]      eng_a_q, eng_a_d;
    logic [VW-1:0]      eng_b_q, eng_b_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   job_count_q, job_count_d;

    // Per-requester operand slices, unpacked for easy selection by index.
    logic [VW-1:0]      a_slice [NREQ];
    logic [VW-1:0]      b_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*VW +: VW];
            assign b_slice[gi] = req_b[gi*VW +: VW];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick: scan last_grant+1, last_grant+2, ... modulo NREQ and
    // take the first requester with req_valid set.
    // -----------------------------------------------------------------------
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    int                 cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_q) + k) % NREQ;
            if (!pick_found && req_valid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    logic accept;
    logic rsp_handshake;

    assign accept        = (state_q == S_IDLE) && cfg_enable && pick_found;
    assign rsp_handshake = (state_q == S_RESP) && rsp_ready[grant_q];

    // -----------------------------------------------------------------------
    // Next-state and datapath-next logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        eng_a_d      = eng_a_q;
        eng_b_d      = eng_b_q;
        rsp_data_d   = rsp_data_q;
        job_count_d  = job_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    eng_a_d = a_slice[pick_idx];
                    eng_b_d = b_slice[pick_idx];
                    grant_d = pick_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_W'(ENGINE_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                // Counter reaching 1 marks the cycle the engine output is valid.
                if (cnt_q == LAT_W'(1)) begin
                    rsp_data_d = eng_out;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_handshake) begin
                    // Fairness pointer only advances once the job is delivered.
                    last_grant_d = grant_q;
                    job_count_d  = job_count_q + CNT_W'(1);
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(NREQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            eng_a_q      <= '0;
            eng_b_q      <= '0;
            rsp_data_q   <= '0;
            job_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            eng_a_q      <= eng_a_d;
            eng_b_q      <= eng_b_d;
            rsp_data_q   <= rsp_data_d;
            job_count_q  <= job_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign req_ready[gi] = accept && (pick_idx == IDX_W'(gi));
            assign rsp_valid[gi] = (state_q == S_RESP) && (grant_q == IDX_W'(gi));
        end
    endgenerate

    assign eng_start = (state_q == S_ISSUE);
    assign eng_a     = eng_a_q;
    assign eng_b     = eng_b_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);
    assign job_count = job_count_q;

endmodule

// File: tb/tb_cim_dot_scheduler.sv
module tb_cim_dot_scheduler;

    localparam int NREQ = 4;
    localparam int SIZE = 2;
    localparam int VW   = 16 * SIZE;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_enable = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*VW-1:0]  req_a = '0;
    logic [NREQ*VW-1:0]  req_b = '0;
    logic                eng_start;
    logic [VW-1:0]       eng_a;
    logic [VW-1:0]       eng_b;
    logic [15:0]         eng_out = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [15:0]         rsp_data;
    logic                busy;
    logic [15:0]         job_count;

    int checks = 0;
    int errors = 0;

    cim_dot_scheduler #(
        .NREQ(NREQ), .SIZE(SIZE), .ENGINE_LAT(10), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_out(eng_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    // Move to the sample point of the next cycle (1 time unit after negedge).
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [VW-1:0] a, input logic [VW-1:0] b);
        req_a[i*VW +: VW] = a;
        req_b[i*VW +: VW] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Advance until req_ready is non-zero or the budget runs out.
    task automatic wait_ready(input int budget, output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < budget; c++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        end
    endtask

    // Advance until rsp_valid is non-zero or the budget runs out.
    task automatic wait_rsp(input int budget, output logic [NREQ-1:0] rv, output bit ok);
        ok = 1'b0;
        rv = '0;
        for (int c = 0; c < budget; c++) begin
            if (rsp_valid != '0) begin
                ok = 1'b1;
                rv = rsp_valid;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({req_ready, eng_start, busy, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b start=%b busy=%b rsp_valid=%b, want all 0",
                     req_ready, eng_start, busy, rsp_valid);
        end
        checks++;
        if (eng_a !== '0 || eng_b !== '0) begin
            errors++;
            $display("FAIL reset_operands: got eng_a=%h eng_b=%h, want 0", eng_a, eng_b);
        end
        checks++;
        if (rsp_data !== 16'h0 || job_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got rsp_data=%h job_count=%0d, want 0", rsp_data, job_count);
        end
        rst = 1'b0;
        $display("reset: outputs idle");
    endtask

    task automatic test_single();
        do_reset();
        set_op(0, {16'h3F80, 16'h4000}, {16'h3F80, 16'h4000});
        eng_out   = 16'h40A0;
        rsp_ready = 4'b0001;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b, want 0001", req_ready);
        end
        step();                      // cycle 1
        req_valid = '0;
        checks++;
        if (eng_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_start: got start=%b busy=%b, want 1 1", eng_start, busy);
        end
        checks++;
        if (eng_a !== {16'h3F80, 16'h4000} || eng_b !== {16'h3F80, 16'h4000}) begin
            errors++;
            $display("FAIL single_operands: got a=%h b=%h, want 3f804000", eng_a, eng_b);
        end
        for (int c = 2; c <= 11; c++) begin
            step();
            checks++;
            if (eng_start !== 1'b0 || rsp_valid !== 4'b0000) begin
                errors++;
                $display("FAIL single_wait c%0d: got start=%b rsp_valid=%b, want 0 0000",
                         c, eng_start, rsp_valid);
            end
        end
        step();                      // cycle 12
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'h40A0) begin
            errors++;
            $display("FAIL single_rsp: got rsp_valid=%b data=%h, want 0001 40a0", rsp_valid, rsp_data);
        end
        step();
        checks++;
        if (job_count !== 16'd1 || busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL single_done: got job_count=%0d busy=%b rsp_valid=%b, want 1 0 0000",
                     job_count, busy, rsp_valid);
        end
        $display("single: requester 0 result %h job_count %0d", rsp_data, job_count);
    endtask

    task automatic test_round_robin();
        int idx;
        bit ok;
        logic [NREQ-1:0] rv;
        logic [NREQ-1:0] want;
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        #1;
        for (int j = 0; j < 8; j++) begin
            eng_out = 16'h4100 + 16'(j);
            wait_ready(30, idx, ok);
            checks++;
            if (!ok || idx != j % 4) begin
                errors++;
                $display("FAIL rr_grant job%0d: got idx=%0d (seen=%0b), want %0d", j, idx, ok, j % 4);
            end
            step();
            wait_rsp(30, rv, ok);
            want = 4'b0001 << (j % 4);
            checks++;
            if (!ok || rv !== want || rsp_data !== 16'h4100 + 16'(j)) begin
                errors++;
                $display("FAIL rr_rsp job%0d: got rsp_valid=%b data=%h, want %b %h",
                         j, rv, rsp_data, want, 16'h4100 + 16'(j));
            end
            $display("rr: job %0d granted %0d rsp_valid %b data %h", j, idx, rv, rsp_data);
            step();
            if (j == 7) req_valid = '0;
        end
        checks++;
        if (job_count !== 16'd8) begin
            errors++;
            $display("FAIL rr_count: got %0d, want 8", job_count);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        bit ok;
        logic [NREQ-1:0] rv;
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 4'b0000;
        eng_out   = 16'h4242;
        #1;
        wait_ready(10, idx, ok);
        checks++;
        if (!ok || idx != 0) begin
            errors++;
            $display("FAIL bp_grant: got idx=%0d, want 0", idx);
        end
        step();
        req_valid = 4'b0011;
        wait_rsp(20, rv, ok);
        eng_out   = 16'h7777;
        rsp_ready = 4'b1110;         // other requesters' ready must not count
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (!ok || rsp_valid !== 4'b0001 || rsp_data !== 16'h4242 ||
                req_ready !== 4'b0000 || eng_start !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold s%0d: got rsp_valid=%b data=%h ready=%b start=%b, want 0001 4242 0000 0",
                         s, rsp_valid, rsp_data, req_ready, eng_start);
            end
            step();
        end
        rsp_ready = 4'b0001;
        #1;
        checks++;
        if (rsp_valid !== 4'b0001) begin
            errors++;
            $display("FAIL bp_still_valid: got %b, want 0001", rsp_valid);
        end
        step();
        checks++;
        if (req_ready !== 4'b0010 || job_count !== 16'd1 || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bp_next_grant: got ready=%b job_count=%0d rsp_valid=%b, want 0010 1 0000",
                     req_ready, job_count, rsp_valid);
        end
        rsp_ready = 4'b1111;
        step();
        req_valid = '0;
        wait_rsp(20, rv, ok);
        checks++;
        if (!ok || rv !== 4'b0010 || rsp_data !== 16'h7777) begin
            errors++;
            $display("FAIL bp_second: got rsp_valid=%b data=%h, want 0010 7777", rv, rsp_data);
        end
        $display("backpressure: held 5 cycles, second job to %b data %h", rv, rsp_data);
        step();
    endtask

    task automatic test_isolation();
        do_reset();
        set_op(0, 32'h1111_2222, 32'h3333_4444);
        req_valid = 4'b0001;
        rsp_ready = 4'b0001;
        eng_out   = 16'hDEAD;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL iso_ready: got %b, want 0001", req_ready);
        end
        step();                      // cycle 1
        set_op(0, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        req_valid = '0;
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (eng_a !== 32'h1111_2222 || eng_b !== 32'h3333_4444) begin
                errors++;
                $display("FAIL iso_operands c%0d: got a=%h b=%h, want 11112222 33334444", c, eng_a, eng_b);
            end
            eng_out = (c == 11) ? 16'h1234 : 16'hDEAD;
            step();
        end
        eng_out = 16'hBEEF;
        #1;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'h1234) begin
            errors++;
            $display("FAIL iso_rsp: got rsp_valid=%b data=%h, want 0001 1234", rsp_valid, rsp_data);
        end
        $display("isolation: operands held, result %h", rsp_data);
        step();
    endtask

    task automatic test_cfg_enable();
        int idx;
        bit ok;
        logic [NREQ-1:0] rv;
        do_reset();
        cfg_enable = 1'b1;
        req_valid  = 4'b0001;
        rsp_ready  = 4'b1111;
        eng_out    = 16'h5555;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL cfg_first: got %b, want 0001", req_ready);
        end
        step();
        req_valid = 4'b1110;
        step();
        step();
        cfg_enable = 1'b0;
        wait_rsp(20, rv, ok);
        checks++;
        if (!ok || rv !== 4'b0001 || rsp_data !== 16'h5555) begin
            errors++;
            $display("FAIL cfg_complete: got rsp_valid=%b data=%h, want 0001 5555", rv, rsp_data);
        end
        step();
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (busy !== 1'b0 || req_ready !== 4'b0000 || eng_start !== 1'b0) begin
                errors++;
                $display("FAIL cfg_parked s%0d: got busy=%b ready=%b start=%b, want 0 0000 0",
                         s, busy, req_ready, eng_start);
            end
            step();
        end
        cfg_enable = 1'b1;
        #1;
        wait_ready(5, idx, ok);
        checks++;
        if (!ok || idx != 1) begin
            errors++;
            $display("FAIL cfg_resume: got idx=%0d, want 1", idx);
        end
        step();
        req_valid = '0;
        wait_rsp(20, rv, ok);
        checks++;
        if (!ok || rv !== 4'b0010) begin
            errors++;
            $display("FAIL cfg_resume_rsp: got %b, want 0010", rv);
        end
        step();
        checks++;
        if (job_count !== 16'd2) begin
            errors++;
            $display("FAIL cfg_count: got %0d, want 2", job_count);
        end
        $display("cfg_enable: parked then resumed at requester %0d", idx);
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100;
        rsp_ready = 4'b1111;
        eng_out   = 16'h6666;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL mid_grant: got %b, want 0100", req_ready);
        end
        step();
        req_valid = '0;
        for (int s = 0; s < 5; s++) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b, want 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({req_ready, eng_start, busy, rsp_valid} !== '0 || eng_a !== '0 || eng_b !== '0 ||
            rsp_data !== 16'h0 || job_count !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_vals: got ready=%b start=%b busy=%b rsp_valid=%b a=%h b=%h data=%h cnt=%0d, want all 0",
                     req_ready, eng_start, busy, rsp_valid, eng_a, eng_b, rsp_data, job_count);
        end
        for (int s = 0; s < 15; s++) begin
            step();
            checks++;
            if (rsp_valid !== 4'b0000 || eng_start !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_rsp s%0d: got rsp_valid=%b start=%b busy=%b, want 0000 0 0",
                         s, rsp_valid, eng_start, busy);
            end
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first_grant: got %b, want 0001", req_ready);
        end
        req_valid = '0;
        $display("reset_mid: job aborted, first grant requester 0");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_isolation();
        test_cfg_enable();
        test_reset_mid();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cim_dot_scheduler.md
Name: cim_dot_scheduler

Overview:
- Shares one BF16 dot-product CIM engine among NREQ requesters.
- Each requester submits a SIZE-element BF16 operand pair (A, B). The scheduler arbitrates round-robin, latches the winner's operands and pulses the engine's start. It waits a fixed engine latency, captures the 16-bit BF16 result and returns it to the winner over a valid/ready handshake.
- Sits between the requesting tiles and the engine. The engine has no done flag, so completion is timed by a counter.

Parameters:
- NREQ, 4, number of requesters (≥2).
- SIZE, 2, BF16 elements per operand vector (matches engine SIZE).
- ENGINE_LAT, 10, cycles from the engine sampling start to its output being valid (≥1).
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  when 0, no new grants; an in-flight job still completes.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot accept strobe; the request is taken when req_valid[i]&req_ready[i].
- req_a  in  NREQ*16*SIZE  requester i's A vector at bits [i*16*SIZE +: 16*SIZE].
- req_b  in  NREQ*16*SIZE  requester i's B vector, same packing.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a  out  16*SIZE  latched A operands, stable from ISSUE through end of WAIT.
- eng_b  out  16*SIZE  latched B operands, same stability rule.
- eng_out  in  16  engine BF16 result.
- rsp_valid  out  NREQ  one-hot response valid to the granted requester.
- rsp_ready  in  NREQ  per-requester response ready.
- rsp_data  out  16  captured BF16 result.
- busy  out  1  high in any state other than IDLE.
- job_count  out  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - Outputs: req_ready=0, eng_start=0, eng_a=0, eng_b=0, rsp_valid=0, rsp_data=0, busy=0, job_count=0.
  - Internal: state=IDLE, last_grant=NREQ-1 (requester 0 is highest priority first), grant=0, lat counter=0.
- Reset applied mid-operation aborts the job: the result is discarded, no response is issued and no eng_start is emitted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If cfg_enable and |req_valid: pick the first set bit scanning last_grant+1, last_grant+2, … wrapping modulo NREQ.
  - req_ready is driven combinationally one-hot to the pick in the same cycle.
  - On that edge: latch req_a/req_b slices into eng_a/eng_b, record grant, go to ISSUE.
  - Otherwise req_ready=0 and state stays IDLE.
- ISSUE: eng_start=1 for exactly this cycle; load counter with ENGINE_LAT; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter==1: rsp_data<=eng_out, go to RESP.
  - WAIT therefore lasts ENGINE_LAT cycles.
- RESP:
  - rsp_valid[grant]=1 and rsp_data held until rsp_ready[grant]=1.
  - On the handshake: last_grant<=grant, job_count<=job_count+1, go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Latency: accept at cycle T → eng_start at T+1 → rsp_valid first asserted at T+2+ENGINE_LAT (12 cycles with defaults).
- Throughput: at most one job in flight. No IDLE bypass: a new grant is earliest one cycle after the response handshake, even if a request is pending during RESP.
- Arbitration: only the head requester is granted per cycle. A requester that drops req_valid before being granted is simply skipped; last_grant updates only on a completed response.
- cfg_enable falling while busy has no effect on the current job; the scheduler then parks in IDLE.
- Changes on req_a/req_b after acceptance do not affect eng_a/eng_b.
- eng_out is sampled only in the final WAIT cycle; its value at any other time is don't-care.
- job_count wraps from 2^CNT_W-1 to 0 silently.

Test Plan:
- Single request: rst, then req_valid=4'b0001 with A=B={16'h3F80,16'h4000} → req_ready[0] at cycle 0, eng_start at cycle 1. Engine model drives 16'h40A0 → rsp_valid=4'b0001, rsp_data=16'h40A0 at cycle 12; job_count=1 after the handshake.
- Round-robin fairness: req_valid=4'b1111 held continuously for 8 jobs → grant order 0,1,2,3,0,1,2,3 and each rsp_valid is one-hot matching that order.
- Response backpressure: rsp_ready[0]=0 for 5 cycles → rsp_valid and rsp_data held stable for those 5 cycles, req_ready stays 0, no eng_start. The next grant occurs exactly 1 cycle after the handshake.
- Operand isolation: change req_a[0] on the cycle after acceptance → eng_a unchanged through WAIT. A wrong eng_out outside the final WAIT cycle does not alter rsp_data.
- cfg_enable=0 during WAIT with other requests pending → the current job completes normally, then there are no grants and busy=0. Re-enable → grant resumes starting at last_grant+1.
- Reset mid-WAIT (rst=1 one cycle) → all outputs return to reset values on the next edge, no rsp_valid for the aborted job, and the first post-reset grant goes to requester 0.
